// File: rtl/fc_argmax_stream.sv
// Streaming argmax over one frame of NUM_CLASSES scores delivered LANES per beat.
// Reports the lowest-indexed maximum score and its class index through a valid/ready output.
module fc_argmax_stream #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10,
  parameter int LANES       = 1,
  parameter int SIGNED      = 1,
  parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_index,
  output logic [DATA_W-1:0]       out_value,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int NBEATS = (NUM_CLASSES + LANES - 1) / LANES;
  localparam int CNT_W  = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   beat_best_val;
  logic [IDX_W-1:0]    beat_best_idx;

  function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Best lane of the current beat; strict compare keeps the lowest lane on ties,
  // and lanes beyond the last class (padding in the final beat) never compete.
  always_comb begin
    int base;
    base          = int'(beat_q) * LANES;
    beat_best_val = in_data[DATA_W-1:0];
    beat_best_idx = IDX_W'(base);
    for (int k = 1; k < LANES; k++) begin
      if ((base + k) < NUM_CLASSES && greater(in_data[k*DATA_W +: DATA_W], beat_best_val)) begin
        beat_best_val = in_data[k*DATA_W +: DATA_W];
        beat_best_idx = IDX_W'(base + k);
      end
    end
  end

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready,
  // the result transfers where out_valid && out_ready; both ready/valid outputs
  // are decoded from state only, so nothing combinational reaches them from inputs.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    max_d   = max_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          beat_d  = '0;
          max_d   = '0;
          idx_d   = '0;
        end
      end
      S_ACCUM: begin
        if (start) begin
          beat_d = '0;
          max_d  = '0;
          idx_d  = '0;
        end else if (in_valid) begin
          // Beat 0 loads unconditionally so an all-negative frame is not beaten by the cleared max.
          if (beat_q == '0 || greater(beat_best_val, max_q)) begin
            max_d = beat_best_val;
            idx_d = beat_best_idx;
          end
          if (beat_q == CNT_W'(NBEATS - 1)) state_d = S_DONE;
          else                               beat_d  = beat_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (start) begin
            state_d = S_ACCUM;
            beat_d  = '0;
            max_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_index = idx_q;
  assign out_value = max_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fc_argmax_stream.sv
// Bench for fc_argmax_stream: a scalar signed instance and a 4-lane unsigned instance,
// each with its own expected queue and output monitor, checked against a plain argmax model.
module tb_fc_argmax_stream;

  logic clk;
  logic rst_n;

  // instance A: defaults (16-bit signed, 10 classes, 1 lane)
  logic        a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_data, a_out_value;
  logic [3:0]  a_out_index;
  logic [1:0]  a_dbg;

  // instance B: 4 lanes, unsigned
  logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [63:0] b_in_data;
  logic [15:0] b_out_value;
  logic [3:0]  b_out_index;
  logic [1:0]  b_dbg;

  logic [19:0] exp_a_q[$];
  logic [19:0] exp_b_q[$];
  logic [15:0] frame_a[10];
  logic [15:0] frame_b[10];

  int checks = 0;
  int errors = 0;

  fc_argmax_stream u_a (
    .clk(clk), .reset(rst_n), .start(a_start),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_index(a_out_index), .out_value(a_out_value),
    .busy(a_busy), .dbg_state(a_dbg)
  );

  fc_argmax_stream #(.DATA_W(16), .NUM_CLASSES(10), .LANES(4), .SIGNED(0)) u_b (
    .clk(clk), .reset(rst_n), .start(b_start),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_index(b_out_index), .out_value(b_out_value),
    .busy(b_busy), .dbg_state(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // reference model: first index holding the largest score
  function automatic logic [19:0] model_a();
    int best = 0;
    for (int i = 1; i < 10; i++)
      if ($signed(frame_a[i]) > $signed(frame_a[best])) best = i;
    return {4'(best), frame_a[best]};
  endfunction

  function automatic logic [19:0] model_b();
    int best = 0;
    for (int i = 1; i < 10; i++)
      if (frame_b[i] > frame_b[best]) best = i;
    return {4'(best), frame_b[best]};
  endfunction

  // driver tasks
  task automatic send_beat_a(input logic [15:0] d, input bit toggle);
    bit acc = 0;
    int n = 0;
    if (toggle) begin
      a_in_valid = 1'b0;
      tick();
    end
    while (!acc && n < 50) begin
      a_in_valid = 1'b1;
      a_in_data  = d;
      acc        = a_in_ready;
      tick();
      n++;
    end
    a_in_valid = 1'b0;
    check("a_beat_accepted", acc, 1);
  endtask

  task automatic send_frame_a(input bit do_start, input bit toggle);
    if (do_start) begin
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
    end
    for (int b = 0; b < 10; b++) send_beat_a(frame_a[b], toggle);
    check("a_valid_after_last_beat", a_out_valid, 1);
  endtask

  task automatic send_frame_b(input logic [15:0] pad);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bit acc = 0;
      int n = 0;
      for (int k = 0; k < 4; k++)
        b_in_data[k*16 +: 16] = (j*4 + k < 10) ? frame_b[j*4 + k] : pad;
      while (!acc && n < 50) begin
        b_in_valid = 1'b1;
        acc        = b_in_ready;
        tick();
        n++;
      end
      b_in_valid = 1'b0;
      check("b_beat_accepted", acc, 1);
    end
    check("b_valid_after_last_beat", b_out_valid, 1);
  endtask

  // monitors
  logic [19:0] held_a;
  bit          held_a_v = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_a_v = 0;
    end else if (a_out_valid) begin
      check("a_in_ready_in_done", a_in_ready, 0);
      if (held_a_v) check("a_stall_stable", {a_out_index, a_out_value}, held_a);
      if (a_out_ready) begin
        held_a_v = 0;
        if (exp_a_q.size() == 0) begin
          check("a_unexpected_result", 1, 0);
        end else begin
          logic [19:0] e;
          e = exp_a_q.pop_front();
          check("a_out_index", a_out_index, e[19:16]);
          check("a_out_value", a_out_value, e[15:0]);
        end
      end else begin
        held_a   = {a_out_index, a_out_value};
        held_a_v = 1;
      end
    end else begin
      held_a_v = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_result", 1, 0);
      end else begin
        logic [19:0] e;
        e = exp_b_q.pop_front();
        check("b_out_index", b_out_index, e[19:16]);
        check("b_out_value", b_out_value, e[15:0]);
      end
    end
  end

  // stimulus
  initial begin
    logic [15:0] tc1[10];
    logic [15:0] tc2[10];
    tc1 = '{16'd3, -16'sd7, 16'd12, 16'd5, 16'd12, 16'd0, -16'sd1, 16'd9, 16'd2, 16'd11};
    tc2 = '{-16'sd5, -16'sd3, -16'sd9, -16'sd3, -16'sd8, -16'sd6, -16'sd4, -16'sd7, -16'sd10, -16'sd11};

    rst_n = 1'b0;
    a_start = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
    b_start = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
    repeat (3) tick();
    check("reset_a_out_valid", a_out_valid, 0);
    check("reset_a_in_ready", a_in_ready, 0);
    check("reset_a_busy", a_busy, 0);
    check("reset_a_result", {a_out_index, a_out_value}, 0);
    check("reset_a_state", a_dbg, 0);
    check("reset_b_result", {b_out_valid, b_out_index, b_out_value}, 0);
    rst_n = 1'b1;
    tick();

    // directed frames: tie resolves low, then an all-negative frame
    frame_a = tc1;
    check("model_tc1", model_a(), {4'd2, 16'd12});
    exp_a_q.push_back(model_a());
    send_frame_a(1, 0);
    frame_a = tc2;
    exp_a_q.push_back(model_a());
    send_frame_a(1, 0);

    // 4-lane unsigned: max in the padded last beat, then pads that must be ignored
    for (int i = 0; i < 9; i++) frame_b[i] = 16'(20 + i);
    frame_b[9] = 16'hFFFF;
    exp_b_q.push_back(model_b());
    send_frame_b(16'hFFFF);
    frame_b[9] = 16'd5;
    exp_b_q.push_back(model_b());
    send_frame_b(16'hFFFF);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 10; i++) frame_b[i] = (f < 4) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      exp_b_q.push_back(model_b());
      send_frame_b(16'($urandom));
    end

    // toggling valid with a stalled consumer; start during the stall is ignored
    a_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) frame_a[i] = 16'($urandom);
    exp_a_q.push_back(model_a());
    send_frame_a(1, 1);
    for (int i = 0; i < 5; i++) begin
      a_start = (i == 2);
      tick();
    end
    a_start = 1'b0;
    check("a_start_ignored_while_stalled", a_out_valid, 1);
    // handshake and start together go straight back to accumulating
    a_out_ready = 1'b1;
    a_start     = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_done_to_accum_ready", a_in_ready, 1);
    check("a_done_to_accum_busy", a_busy, 1);
    for (int i = 0; i < 10; i++) frame_a[i] = 16'($urandom_range(0, 31)) - 16'd16;
    exp_a_q.push_back(model_a());
    send_frame_a(0, 0);
    tick();
    check("a_idle_after_handshake_busy", a_busy, 0);
    check("a_idle_after_handshake_valid", a_out_valid, 0);

    // abort after beat 4, including a beat presented with the restarting start
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int b = 0; b < 5; b++) send_beat_a(16'h7FFF, 0);
    a_start    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 16'h7FFF;
    tick();
    a_start    = 1'b0;
    a_in_valid = 1'b0;
    for (int i = 0; i < 10; i++) frame_a[i] = 16'($urandom_range(0, 200)) - 16'd100;
    frame_a[7] = 16'd500;
    check("model_abort", model_a(), {4'd7, 16'd500});
    exp_a_q.push_back(model_a());
    send_frame_a(0, 0);
    tick();

    // reset mid-frame after beat 6
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int b = 0; b < 7; b++) send_beat_a(16'h7FFF, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_a_busy", a_busy, 0);
    check("midreset_a_in_ready", a_in_ready, 0);
    check("midreset_a_out_valid", a_out_valid, 0);
    check("midreset_a_result", {a_out_index, a_out_value}, 0);
    tick();
    check("midreset_a_state", a_dbg, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) frame_a[i] = 16'($urandom);
    exp_a_q.push_back(model_a());
    send_frame_a(1, 0);

    // random frames: narrow range for ties, full range for sign coverage
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 10; i++)
        frame_a[i] = (f < 10) ? 16'($urandom_range(0, 7)) - 16'd4 : 16'($urandom);
      exp_a_q.push_back(model_a());
      send_frame_a(1, f[0]);
    end

    repeat (5) tick();
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
